// File: rtl/lcd_sequencer_pkg.sv
// Shared types and constants for the HD44780-style LCD sequencer:
// state encoding, instruction codes, the power-on init table and
// the rule deciding which instructions need the long execution wait.
package lcd_pkg;

    typedef enum logic [2:0] {
        ST_POWERUP,
        ST_INIT,
        ST_IDLE,
        ST_SETUP,
        ST_PULSE,
        ST_HOLD,
        ST_WAIT
    } state_t;

    localparam logic [7:0] CMD_CLEAR     = 8'h01;
    localparam logic [7:0] CMD_HOME      = 8'h02;
    localparam logic [7:0] CMD_FUNC_8B2L = 8'h38;
    localparam logic [7:0] CMD_DISP_ON   = 8'h0C;
    localparam logic [7:0] CMD_ENTRY_INC = 8'h06;

    localparam int INIT_LEN = 6;

    // Entry 0 sits in the low byte and is issued first.
    localparam logic [INIT_LEN-1:0][7:0] INIT_TABLE = {
        CMD_ENTRY_INC, CMD_CLEAR, CMD_DISP_ON,
        CMD_FUNC_8B2L, CMD_FUNC_8B2L, CMD_FUNC_8B2L
    };

    // Clear and return-home (0x02 and its alias 0x03) take ~1.5 ms to execute.
    function automatic logic is_long_cmd(input logic rs, input logic [7:0] data);
        return !rs && ((data == CMD_CLEAR) || (data == CMD_HOME) || (data == 8'h03));
    endfunction

endpackage

// File: rtl/lcd_sequencer_if.sv
// Processor-side byte write request channel (valid/ready) of the LCD sequencer.
interface lcd_sequencer_if;
    logic       req_valid;
    logic       req_rs;
    logic [7:0] req_data;
    logic       req_ready;
    logic       busy;

    modport master (output req_valid, req_rs, req_data, input req_ready, busy);
    modport slave  (input req_valid, req_rs, req_data, output req_ready, busy);
endinterface

// File: rtl/lcd_timer.sv
// Loadable down-counter with a zero flag; holds at zero until reloaded.
module lcd_timer #(
    parameter int CNT_W = 22
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             zero
);

    logic [CNT_W-1:0] cnt_reg;

    // Reload has priority over counting; saturate at zero.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)
            cnt_reg <= '0;
        else if (load)
            cnt_reg <= load_val;
        else if (cnt_reg != '0)
            cnt_reg <= cnt_reg - CNT_W'(1);
    end

    assign zero = (cnt_reg == '0);

endmodule

// File: rtl/lcd_sequencer.sv
// HD44780 bus sequencer: accepts byte writes and produces setup / enable /
// hold / execution-wait timing on registered LCD pins.
// Optional power-on init sequence is built when LCD_INIT_EN is defined.
module lcd_sequencer
    import lcd_pkg::*;
#(
    parameter int SETUP_CYC      = 4,
    parameter int EN_CYC         = 25,
    parameter int HOLD_CYC       = 4,
    parameter int WAIT_SHORT_CYC = 2500,
    parameter int WAIT_LONG_CYC  = 85000,
    parameter int POWERUP_CYC    = 2000000,
    parameter int CNT_W          = 22
) (
    input  logic        clock,
    input  logic        reset_n,
    lcd_sequencer_if.slave req,
    output logic [7:0]  lcd_data,
    output logic        lcd_en,
    output logic        lcd_rs,
    output logic        lcd_rw
);

    localparam logic [CNT_W-1:0] SETUP_LD = CNT_W'(SETUP_CYC - 1);
    localparam logic [CNT_W-1:0] EN_LD    = CNT_W'(EN_CYC - 1);
    localparam logic [CNT_W-1:0] HOLD_LD  = CNT_W'(HOLD_CYC - 1);
    localparam logic [CNT_W-1:0] WS_LD    = CNT_W'(WAIT_SHORT_CYC - 1);
    localparam logic [CNT_W-1:0] WL_LD    = CNT_W'(WAIT_LONG_CYC - 1);

`ifdef LCD_INIT_EN
    localparam state_t RESET_STATE = ST_POWERUP;
    // One POWERUP cycle is spent arming the timer, so load two short.
    localparam logic [CNT_W-1:0] PWR_LD = CNT_W'((POWERUP_CYC >= 2) ? POWERUP_CYC - 2 : 0);
`else
    localparam state_t RESET_STATE = ST_IDLE;
`endif

    state_t           state_reg, state_next;
    logic [7:0]       lcd_data_reg, lcd_data_next;
    logic             lcd_rs_reg, lcd_rs_next;
    logic             lcd_en_reg, lcd_en_next;
    logic             wait_long_reg, wait_long_next;
    logic             timer_load;
    logic [CNT_W-1:0] timer_val;
    logic             timer_zero;

`ifdef LCD_INIT_EN
    logic [2:0]       init_idx_reg, init_idx_next;
    logic             pwr_armed_reg, pwr_armed_next;

    // Init table position and power-on timer arming flag.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            init_idx_reg  <= '0;
            pwr_armed_reg <= 1'b0;
        end else begin
            init_idx_reg  <= init_idx_next;
            pwr_armed_reg <= pwr_armed_next;
        end
    end
`endif

    lcd_timer #(.CNT_W(CNT_W)) u_timer (
        .clock    (clock),
        .reset_n  (reset_n),
        .load     (timer_load),
        .load_val (timer_val),
        .zero     (timer_zero)
    );

    // State register and registered LCD pins; reset drops lcd_en at once.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_reg     <= RESET_STATE;
            lcd_data_reg  <= 8'h00;
            lcd_rs_reg    <= 1'b0;
            lcd_en_reg    <= 1'b0;
            wait_long_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            lcd_data_reg  <= lcd_data_next;
            lcd_rs_reg    <= lcd_rs_next;
            lcd_en_reg    <= lcd_en_next;
            wait_long_reg <= wait_long_next;
        end
    end

    // Next state, timer reloads on each state entry, and next pin values.
    always_comb begin
        state_next     = state_reg;
        lcd_data_next  = lcd_data_reg;
        lcd_rs_next    = lcd_rs_reg;
        wait_long_next = wait_long_reg;
        timer_load     = 1'b0;
        timer_val      = '0;
`ifdef LCD_INIT_EN
        init_idx_next  = init_idx_reg;
        pwr_armed_next = pwr_armed_reg;
`endif
        case (state_reg)
`ifdef LCD_INIT_EN
            ST_POWERUP: begin
                if (!pwr_armed_reg) begin
                    pwr_armed_next = 1'b1;
                    timer_load     = 1'b1;
                    timer_val      = PWR_LD;
                end else if (timer_zero) begin
                    state_next = ST_INIT;
                end
            end
            ST_INIT: begin
                lcd_rs_next    = 1'b0;
                lcd_data_next  = INIT_TABLE[init_idx_reg];
                // The first function-set needs the long wait after power-up.
                wait_long_next = (init_idx_reg == 3'd0) ||
                                 is_long_cmd(1'b0, INIT_TABLE[init_idx_reg]);
                init_idx_next  = init_idx_reg + 3'd1;
                timer_load     = 1'b1;
                timer_val      = SETUP_LD;
                state_next     = ST_SETUP;
            end
`endif
            ST_IDLE: begin
                if (req.req_valid) begin
                    lcd_rs_next    = req.req_rs;
                    lcd_data_next  = req.req_data;
                    wait_long_next = is_long_cmd(req.req_rs, req.req_data);
                    timer_load     = 1'b1;
                    timer_val      = SETUP_LD;
                    state_next     = ST_SETUP;
                end
            end
            ST_SETUP: begin
                if (timer_zero) begin
                    timer_load = 1'b1;
                    timer_val  = EN_LD;
                    state_next = ST_PULSE;
                end
            end
            ST_PULSE: begin
                if (timer_zero) begin
                    timer_load = 1'b1;
                    timer_val  = HOLD_LD;
                    state_next = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (timer_zero) begin
                    timer_load = 1'b1;
                    timer_val  = wait_long_reg ? WL_LD : WS_LD;
                    state_next = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (timer_zero) begin
`ifdef LCD_INIT_EN
                    state_next = (init_idx_reg == 3'(INIT_LEN)) ? ST_IDLE : ST_INIT;
`else
                    state_next = ST_IDLE;
`endif
                end
            end
            default: state_next = ST_IDLE;
        endcase
        lcd_en_next = (state_next == ST_PULSE);
    end

    assign lcd_data      = lcd_data_reg;
    assign lcd_rs        = lcd_rs_reg;
    assign lcd_en        = lcd_en_reg;
    assign lcd_rw        = 1'b0;
    assign req.req_ready = (state_reg == ST_IDLE);
    assign req.busy      = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_lcd_sequencer.sv
// Directed bench for lcd_sequencer with a strobe scoreboard.
// Build with LCD_INIT_EN defined to exercise the power-on init sequence.
module tb_lcd_sequencer;

    localparam int SETUP = 2, EN = 3, HOLD = 2, WS = 10, WL = 40, PWR = 50;
    localparam int T_SHORT = SETUP + EN + HOLD + WS;
    localparam int T_LONG  = SETUP + EN + HOLD + WL;
    localparam int BUDGET  = 3000;
`ifdef LCD_INIT_EN
    localparam bit RST_READY = 1'b0;
`else
    localparam bit RST_READY = 1'b1;
`endif

    typedef struct { logic rs; logic [7:0] data; } exp_t;
    exp_t sb_q[$];

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic [7:0] lcd_data;
    logic       lcd_en, lcd_rs, lcd_rw;
    int         compared = 0;
    int         mismatched = 0;
    int         strobes = 0;

    lcd_sequencer_if req_if ();

    lcd_sequencer #(
        .SETUP_CYC(SETUP), .EN_CYC(EN), .HOLD_CYC(HOLD),
        .WAIT_SHORT_CYC(WS), .WAIT_LONG_CYC(WL), .POWERUP_CYC(PWR), .CNT_W(22)
    ) dut (
        .clock    (clock),
        .reset_n  (reset_n),
        .req      (req_if),
        .lcd_data (lcd_data),
        .lcd_en   (lcd_en),
        .lcd_rs   (lcd_rs),
        .lcd_rw   (lcd_rw)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: each rising edge of lcd_en must match the oldest expected byte.
    bit en_prev = 1'b0;
    int en_len = 0;
    always @(negedge clock) begin
        if (!reset_n) begin
            en_prev = 1'b0;
            en_len  = 0;
        end else begin
            if (lcd_en && !en_prev) begin
                exp_t e;
                strobes++;
                en_len = 1;
                if (sb_q.size() == 0) begin
                    compared++;
                    mismatched++;
                    $error("FAIL strobe_unexpected: observed rs=%0b data=0x%0h expected no strobe", lcd_rs, lcd_data);
                end else begin
                    e = sb_q.pop_front();
                    chk("strobe_rs", {31'd0, lcd_rs}, {31'd0, e.rs});
                    chk("strobe_data", {24'd0, lcd_data}, {24'd0, e.data});
                    chk("strobe_rw", {31'd0, lcd_rw}, 32'd0);
                    $display("strobe %0d: rs=%0b data=0x%02h", strobes, lcd_rs, lcd_data);
                end
            end else if (lcd_en) begin
                en_len++;
            end else if (en_prev) begin
                chk("en_width", en_len, EN);
            end
            en_prev = lcd_en;
        end
    end

    // Count busy cycles after an acceptance, stopping at the first ready negedge.
    task automatic run_busy(output int n_busy, output int first_en, output int n_en,
                            output bit rw_bad, output bit data_moved);
        logic [7:0] first_data;
        n_busy = 0; first_en = 0; n_en = 0; rw_bad = 0; data_moved = 0;
        first_data = 8'h00;
        for (int i = 1; i <= BUDGET; i++) begin
            @(negedge clock);
            if (req_if.req_ready) break;
            n_busy++;
            if (i == 1) first_data = lcd_data;
            else if (lcd_data !== first_data) data_moved = 1;
            if (lcd_en) begin
                n_en++;
                if (first_en == 0) first_en = i;
            end
            if (lcd_rw !== 1'b0) rw_bad = 1;
        end
        chk("ready_timeout", {31'd0, req_if.req_ready}, 32'd1);
    endtask

    task automatic wait_ready();
        for (int i = 0; i < BUDGET && !req_if.req_ready; i++) @(negedge clock);
    endtask

    // Present one request at a negedge and follow it until ready returns.
    task automatic xfer(input logic rs, input logic [7:0] data, input int exp_busy,
                        input bit scramble);
        int nb, fe, ne;
        bit rwb, dm;
        wait_ready();
        req_if.req_valid = 1'b1;
        req_if.req_rs    = rs;
        req_if.req_data  = data;
        sb_q.push_back('{rs, data});
        @(posedge clock);
        #1;
        req_if.req_valid = 1'b0;
        if (scramble) begin
            req_if.req_rs   = ~rs;
            req_if.req_data = ~data;
        end
        run_busy(nb, fe, ne, rwb, dm);
        chk("busy_len", nb, exp_busy);
        chk("en_start", fe, SETUP + 1);
        chk("en_cycles", ne, EN);
        chk("rw_low", {31'd0, rwb}, 32'd0);
        chk("data_stable", {31'd0, dm}, 32'd0);
        chk("data_hold", {24'd0, lcd_data}, {24'd0, data});
        $display("xfer rs=%0b data=0x%02h busy=%0d en_start=%0d", rs, data, nb, fe);
    endtask

    task automatic push_init();
        sb_q.push_back('{1'b0, 8'h38});
        sb_q.push_back('{1'b0, 8'h38});
        sb_q.push_back('{1'b0, 8'h38});
        sb_q.push_back('{1'b0, 8'h0C});
        sb_q.push_back('{1'b0, 8'h01});
        sb_q.push_back('{1'b0, 8'h06});
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int nb, fe, ne, total;
        bit rwb, dm;
        req_if.req_valid = 1'b0;
        req_if.req_rs    = 1'b0;
        req_if.req_data  = 8'h00;
`ifdef LCD_INIT_EN
        push_init();
`endif
        repeat (3) @(negedge clock);
        chk("rst_en", {31'd0, lcd_en}, 32'd0);
        chk("rst_rs", {31'd0, lcd_rs}, 32'd0);
        chk("rst_data", {24'd0, lcd_data}, 32'd0);
        chk("rst_ready", {31'd0, req_if.req_ready}, {31'd0, RST_READY});
        reset_n = 1'b1;
        @(negedge clock);
        chk("post_rst_ready", {31'd0, req_if.req_ready}, {31'd0, RST_READY});
        chk("post_rst_busy", {31'd0, req_if.busy}, {31'd0, ~RST_READY});
        chk("post_rst_rw", {31'd0, lcd_rw}, 32'd0);

`ifdef LCD_INIT_EN
        // Power-on delay: no strobe and no ready during the first PWR cycles.
        repeat (PWR - 5) @(negedge clock);
        chk("pwr_no_strobe", strobes, 0);
        chk("pwr_not_ready", {31'd0, req_if.req_ready}, 32'd0);
        wait_ready();
        chk("init_strobes", strobes, 6);
        chk("init_sb_empty", sb_q.size(), 0);
        $display("init sequence done, strobes=%0d", strobes);
`endif

        // Single data write, then long/short instruction waits.
        xfer(1'b1, 8'h41, T_SHORT, 1'b0);
        xfer(1'b0, 8'h01, T_LONG,  1'b0);
        xfer(1'b0, 8'h80, T_SHORT, 1'b0);
        xfer(1'b0, 8'h02, T_LONG,  1'b0);
        xfer(1'b0, 8'h03, T_LONG,  1'b0);
        xfer(1'b1, 8'h01, T_SHORT, 1'b0);
        xfer(1'b0, 8'h04, T_SHORT, 1'b0);

        // Back-to-back: valid held high, next byte presented right after acceptance.
        wait_ready();
        total = 0;
        req_if.req_valid = 1'b1;
        req_if.req_rs    = 1'b1;
        req_if.req_data  = 8'hA1;
        sb_q.push_back('{1'b1, 8'hA1});
        for (int k = 0; k < 3; k++) begin
            @(posedge clock);
            #1;
            if (k == 0) begin
                req_if.req_data = 8'hB2;
                sb_q.push_back('{1'b1, 8'hB2});
            end else if (k == 1) begin
                req_if.req_data = 8'hC3;
                sb_q.push_back('{1'b1, 8'hC3});
            end else begin
                req_if.req_valid = 1'b0;
            end
            run_busy(nb, fe, ne, rwb, dm);
            chk("b2b_busy", nb, T_SHORT);
            total += nb;
        end
        chk("b2b_total", total, 3 * T_SHORT);
        chk("b2b_sb_empty", sb_q.size(), 0);
        $display("back-to-back total busy=%0d", total);

        // Inputs change while busy; latched byte must not move.
        xfer(1'b1, 8'h55, T_SHORT, 1'b1);

        // Reset during the enable pulse.
        wait_ready();
        req_if.req_valid = 1'b1;
        req_if.req_rs    = 1'b1;
        req_if.req_data  = 8'h66;
        sb_q.push_back('{1'b1, 8'h66});
        @(posedge clock);
        #1;
        req_if.req_valid = 1'b0;
        for (int i = 0; i < 20 && !lcd_en; i++) @(negedge clock);
        chk("rst_mid_en_seen", {31'd0, lcd_en}, 32'd1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("rst_mid_en_drop", {31'd0, lcd_en}, 32'd0);
        chk("rst_mid_data", {24'd0, lcd_data}, 32'd0);
        chk("rst_mid_rs", {31'd0, lcd_rs}, 32'd0);
`ifdef LCD_INIT_EN
        push_init();
`endif
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        chk("rst_rel_ready", {31'd0, req_if.req_ready}, {31'd0, RST_READY});
        chk("rst_rel_en", {31'd0, lcd_en}, 32'd0);
        chk("rst_rel_data", {24'd0, lcd_data}, 32'd0);
        $display("reset during pulse recovered");

        xfer(1'b0, 8'h03, T_LONG, 1'b0);
        chk("final_sb_empty", sb_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
